// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive controller slice.
// Holds legal prescale values, FSM state encoding and idle-counter width.
package uart_pkg;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Wide enough for the largest threshold, 63 * 11 = 693.
  localparam int IDLE_CNT_WIDTH = 10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2
  } rx_state_t;

  function automatic logic prescale_is_legal(input logic [5:0] prescale);
    return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
           (prescale == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head byte and wrap-bit pointers.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_event,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic [ADDR_W:0]       wr_ptr_next;
  logic [ADDR_W:0]       rd_ptr_next;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  empty_next;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign pop_ok         = pop && !empty;
  assign push_ok        = push && (!full || pop_ok);
  assign overflow_event = push && full && !pop_ok;

  assign wr_ptr_next = push_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_ptr_next = pop_ok  ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign empty_next  = (wr_ptr_next == rd_ptr_next);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  // The head is registered, so a byte landing in the next head slot is forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_data <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (empty_next) begin
        head_data <= '0;
      end else if (push_ok && (wr_ptr[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0])) begin
        head_data <= push_data;
      end else begin
        head_data <= mem[rd_ptr_next[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// Configures and sequences the UART receiver: shadowed configuration applied
// only on an idle line, receive FIFO, and saturating error statistics.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 11,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_write,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_parity_enable,
  input  logic                  cfg_parity_type,
  output logic                  cfg_busy,
  output logic                  cfg_reject,
  input  logic                  serial_data_in,
  output logic                  rx_reset_n,
  output logic [5:0]            rx_prescale,
  output logic                  rx_parity_enable,
  output logic                  rx_parity_type,
  input  logic                  rx_data_valid,
  input  logic [DATA_WIDTH-1:0] rx_parallel_data,
  input  logic                  rx_parity_error,
  input  logic                  rx_frame_error,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  parity_err_count,
  output logic [CNT_WIDTH-1:0]  frame_err_count,
  output logic                  overflow,
  input  logic                  status_clear
);

  localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_BITS_W = IDLE_CNT_WIDTH'(IDLE_BITS);
  localparam logic [IDLE_CNT_WIDTH-1:0] IDLE_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE     = 1;
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX     = '1;

  rx_state_t                 state;
  logic [5:0]                shadow_prescale;
  logic                      shadow_parity_enable;
  logic                      shadow_parity_type;
  logic                      post_reset;
  logic [IDLE_CNT_WIDTH-1:0] idle_cnt;
  logic [IDLE_CNT_WIDTH-1:0] idle_threshold;
  logic                      line_idle;
  logic                      parity_prev;
  logic                      frame_prev;
  logic                      parity_edge;
  logic                      frame_edge;
  logic                      fifo_push;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_overflow_event;

  assign idle_threshold = IDLE_CNT_WIDTH'(rx_prescale) * IDLE_BITS_W;
  assign line_idle      = (idle_cnt == idle_threshold);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state == FLUSH || !serial_data_in) begin
      idle_cnt <= '0;
    end else if (idle_cnt < idle_threshold) begin
      idle_cnt <= idle_cnt + IDLE_ONE;
    end
  end

  // Outputs are registered alongside the state so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= RUN;
      shadow_prescale      <= PRESCALE_8;
      shadow_parity_enable <= 1'b0;
      shadow_parity_type   <= 1'b0;
      rx_prescale          <= PRESCALE_8;
      rx_parity_enable     <= 1'b0;
      rx_parity_type       <= 1'b0;
      rx_reset_n           <= 1'b0;
      post_reset           <= 1'b1;
      cfg_busy             <= 1'b0;
      cfg_reject           <= 1'b0;
    end else begin
      cfg_reject <= 1'b0;
      post_reset <= 1'b0;
      rx_reset_n <= !post_reset;
      case (state)
        RUN: begin
          if (cfg_write) begin
            if (prescale_is_legal(cfg_prescale)) begin
              shadow_prescale      <= cfg_prescale;
              shadow_parity_enable <= cfg_parity_enable;
              shadow_parity_type   <= cfg_parity_type;
              cfg_busy             <= 1'b1;
              if (line_idle) begin
                state            <= FLUSH;
                rx_prescale      <= cfg_prescale;
                rx_parity_enable <= cfg_parity_enable;
                rx_parity_type   <= cfg_parity_type;
                rx_reset_n       <= 1'b0;
              end else begin
                state <= PENDING;
              end
            end else begin
              cfg_reject <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (cfg_write) begin
            cfg_reject <= 1'b1;
          end
          if (line_idle) begin
            state            <= FLUSH;
            rx_prescale      <= shadow_prescale;
            rx_parity_enable <= shadow_parity_enable;
            rx_parity_type   <= shadow_parity_type;
            rx_reset_n       <= 1'b0;
          end
        end
        FLUSH: begin
          if (cfg_write) begin
            cfg_reject <= 1'b1;
          end
          state    <= RUN;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= RUN;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_push = rx_data_valid && rx_reset_n;
  assign m_valid   = !fifo_empty;

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push           (fifo_push),
    .push_data      (rx_parallel_data),
    .pop            (m_ready),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .overflow_event (fifo_overflow_event),
    .head_data      (m_data)
  );

  // The receiver may hold an error level for several cycles, so count edges only.
  assign parity_edge = rx_parity_error && !parity_prev;
  assign frame_edge  = rx_frame_error && !frame_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_prev      <= 1'b0;
      frame_prev       <= 1'b0;
      parity_err_count <= '0;
      frame_err_count  <= '0;
      overflow         <= 1'b0;
    end else begin
      parity_prev <= rx_parity_error;
      frame_prev  <= rx_frame_error;
      if (status_clear) begin
        parity_err_count <= parity_edge ? CNT_ONE : '0;
        frame_err_count  <= frame_edge ? CNT_ONE : '0;
        overflow         <= fifo_overflow_event && fifo_full;
      end else begin
        if (parity_edge && parity_err_count != CNT_MAX) begin
          parity_err_count <= parity_err_count + CNT_ONE;
        end
        if (frame_edge && frame_err_count != CNT_MAX) begin
          frame_err_count <= frame_err_count + CNT_ONE;
        end
        if (fifo_overflow_event && fifo_full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller: configuration sequencing,
// FIFO ordering/overflow, and error counter saturation and clearing.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_write;
  logic [5:0] cfg_prescale;
  logic       cfg_parity_enable;
  logic       cfg_parity_type;
  logic       cfg_busy;
  logic       cfg_reject;
  logic       serial_data_in;
  logic       rx_reset_n;
  logic [5:0] rx_prescale;
  logic       rx_parity_enable;
  logic       rx_parity_type;
  logic       rx_data_valid;
  logic [7:0] rx_parallel_data;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [7:0] parity_err_count;
  logic [7:0] frame_err_count;
  logic       overflow;
  logic       status_clear;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] burst_bytes [5];
  logic [7:0] full_bytes  [4];

  always #5 clk = ~clk;

  uart_rx_controller #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .IDLE_BITS  (11),
    .CNT_WIDTH  (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_write         (cfg_write),
    .cfg_prescale      (cfg_prescale),
    .cfg_parity_enable (cfg_parity_enable),
    .cfg_parity_type   (cfg_parity_type),
    .cfg_busy          (cfg_busy),
    .cfg_reject        (cfg_reject),
    .serial_data_in    (serial_data_in),
    .rx_reset_n        (rx_reset_n),
    .rx_prescale       (rx_prescale),
    .rx_parity_enable  (rx_parity_enable),
    .rx_parity_type    (rx_parity_type),
    .rx_data_valid     (rx_data_valid),
    .rx_parallel_data  (rx_parallel_data),
    .rx_parity_error   (rx_parity_error),
    .rx_frame_error    (rx_frame_error),
    .m_valid           (m_valid),
    .m_data            (m_data),
    .m_ready           (m_ready),
    .parity_err_count  (parity_err_count),
    .frame_err_count   (frame_err_count),
    .overflow          (overflow),
    .status_clear      (status_clear)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change only on the falling edge; outputs are sampled there too.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    burst_bytes[0] = 8'h6A; burst_bytes[1] = 8'hA5; burst_bytes[2] = 8'hF7;
    burst_bytes[3] = 8'h5A; burst_bytes[4] = 8'h88;
    full_bytes[0] = 8'h11; full_bytes[1] = 8'h22;
    full_bytes[2] = 8'h33; full_bytes[3] = 8'h44;

    reset = 1'b1; cfg_write = 1'b0; cfg_prescale = 6'd8;
    cfg_parity_enable = 1'b0; cfg_parity_type = 1'b0;
    serial_data_in = 1'b1; rx_data_valid = 1'b0; rx_parallel_data = 8'h00;
    rx_parity_error = 1'b0; rx_frame_error = 1'b0; m_ready = 1'b0;
    status_clear = 1'b0;
    applyStimulus(2);

    checkOutput("reset_rx_reset_n", 32'(rx_reset_n), 32'd0);
    checkOutput("reset_prescale", 32'(rx_prescale), 32'd8);
    checkOutput("reset_parity_en", 32'(rx_parity_enable), 32'd0);
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_m_data", 32'(m_data), 32'd0);
    checkOutput("reset_counts", 32'({parity_err_count, frame_err_count}), 32'd0);
    checkOutput("reset_flags", 32'({overflow, cfg_busy, cfg_reject}), 32'd0);

    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_reset_hold", 32'(rx_reset_n), 32'd0);
    applyStimulus(1);
    checkOutput("post_reset_release", 32'(rx_reset_n), 32'd1);

    // Idle line: a legal write goes straight to the one-cycle flush.
    applyStimulus(100);
    cfg_write = 1'b1; cfg_prescale = 6'd16; cfg_parity_enable = 1'b1; cfg_parity_type = 1'b1;
    applyStimulus(1);
    cfg_write = 1'b0;
    checkOutput("idle_flush_reset_n", 32'(rx_reset_n), 32'd0);
    checkOutput("idle_flush_busy", 32'(cfg_busy), 32'd1);
    checkOutput("idle_flush_prescale", 32'(rx_prescale), 32'd16);
    checkOutput("idle_flush_parity", 32'({rx_parity_enable, rx_parity_type}), 32'd3);
    applyStimulus(1);
    checkOutput("idle_done_busy", 32'(cfg_busy), 32'd0);
    checkOutput("idle_done_reset_n", 32'(rx_reset_n), 32'd1);

    // Illegal prescale is rejected for one cycle with no change.
    cfg_write = 1'b1; cfg_prescale = 6'd12; cfg_parity_enable = 1'b0; cfg_parity_type = 1'b0;
    applyStimulus(1);
    cfg_write = 1'b0;
    checkOutput("illegal_reject", 32'(cfg_reject), 32'd1);
    checkOutput("illegal_busy", 32'(cfg_busy), 32'd0);
    checkOutput("illegal_prescale", 32'(rx_prescale), 32'd16);
    applyStimulus(1);
    checkOutput("illegal_reject_end", 32'(cfg_reject), 32'd0);

    reset = 1'b1;
    applyStimulus(2);
    checkOutput("rereset_prescale", 32'(rx_prescale), 32'd8);
    checkOutput("rereset_parity", 32'({rx_parity_enable, rx_parity_type}), 32'd0);
    reset = 1'b0;
    applyStimulus(2);

    // Write while the line is low stays pending until 88 high cycles have passed.
    serial_data_in = 1'b0;
    applyStimulus(2);
    cfg_write = 1'b1; cfg_prescale = 6'd16; cfg_parity_enable = 1'b1; cfg_parity_type = 1'b1;
    applyStimulus(1);
    cfg_write = 1'b0;
    checkOutput("pending_busy", 32'(cfg_busy), 32'd1);
    checkOutput("pending_prescale", 32'(rx_prescale), 32'd8);
    checkOutput("pending_no_reject", 32'(cfg_reject), 32'd0);
    cfg_write = 1'b1; cfg_prescale = 6'd32; cfg_parity_enable = 1'b0; cfg_parity_type = 1'b0;
    applyStimulus(1);
    cfg_write = 1'b0;
    checkOutput("pending_reject", 32'(cfg_reject), 32'd1);
    applyStimulus(1);
    checkOutput("pending_reject_end", 32'(cfg_reject), 32'd0);
    serial_data_in = 1'b1;
    applyStimulus(88);
    checkOutput("pending_88_busy", 32'(cfg_busy), 32'd1);
    checkOutput("pending_88_prescale", 32'(rx_prescale), 32'd8);
    applyStimulus(1);
    checkOutput("pending_flush_prescale", 32'(rx_prescale), 32'd16);
    checkOutput("pending_flush_reset_n", 32'(rx_reset_n), 32'd0);
    checkOutput("pending_flush_parity", 32'({rx_parity_enable, rx_parity_type}), 32'd3);
    applyStimulus(1);
    checkOutput("pending_done_busy", 32'(cfg_busy), 32'd0);
    checkOutput("pending_done_reset_n", 32'(rx_reset_n), 32'd1);

    // Five bytes into a four-entry FIFO: the last one is dropped.
    for (int i = 0; i < 5; i++) begin
      rx_data_valid = 1'b1; rx_parallel_data = burst_bytes[i];
      applyStimulus(1);
    end
    rx_data_valid = 1'b0;
    checkOutput("burst_overflow", 32'(overflow), 32'd1);
    checkOutput("burst_m_valid", 32'(m_valid), 32'd1);
    applyStimulus(2);
    checkOutput("burst_head_stable", 32'(m_data), 32'h6A);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_valid", 32'(m_valid), 32'd1);
      checkOutput("drain_data", 32'(m_data), 32'(burst_bytes[i]));
      applyStimulus(1);
    end
    m_ready = 1'b0;
    checkOutput("drain_empty", 32'(m_valid), 32'd0);

    status_clear = 1'b1;
    applyStimulus(1);
    status_clear = 1'b0;
    checkOutput("clear_overflow", 32'(overflow), 32'd0);

    // Full FIFO with push and pop together keeps four entries and no overflow.
    for (int i = 0; i < 4; i++) begin
      rx_data_valid = 1'b1; rx_parallel_data = full_bytes[i];
      applyStimulus(1);
    end
    checkOutput("full_head", 32'(m_data), 32'h11);
    rx_parallel_data = 8'h55; m_ready = 1'b1;
    applyStimulus(1);
    rx_data_valid = 1'b0; m_ready = 1'b0;
    checkOutput("pushpop_no_overflow", 32'(overflow), 32'd0);
    checkOutput("pushpop_head", 32'(m_data), 32'h22);
    rx_data_valid = 1'b1; rx_parallel_data = 8'h66;
    applyStimulus(1);
    rx_data_valid = 1'b0;
    checkOutput("still_full_overflow", 32'(overflow), 32'd1);
    m_ready = 1'b1;
    checkOutput("pushpop_drain0", 32'(m_data), 32'h22);
    applyStimulus(1);
    checkOutput("pushpop_drain1", 32'(m_data), 32'h33);
    applyStimulus(1);
    checkOutput("pushpop_drain2", 32'(m_data), 32'h44);
    applyStimulus(1);
    checkOutput("pushpop_drain3", 32'(m_data), 32'h55);
    applyStimulus(1);
    m_ready = 1'b0;
    checkOutput("pushpop_empty", 32'(m_valid), 32'd0);

    // A held parity error counts once; a separate pulse counts again.
    rx_parity_error = 1'b1;
    applyStimulus(3);
    rx_parity_error = 1'b0;
    applyStimulus(1);
    rx_parity_error = 1'b1;
    applyStimulus(1);
    rx_parity_error = 1'b0;
    applyStimulus(1);
    checkOutput("parity_count", 32'(parity_err_count), 32'd2);

    for (int i = 0; i < 300; i++) begin
      rx_frame_error = 1'b1;
      applyStimulus(1);
      rx_frame_error = 1'b0;
      applyStimulus(1);
    end
    checkOutput("frame_saturate", 32'(frame_err_count), 32'd255);

    status_clear = 1'b1;
    applyStimulus(1);
    status_clear = 1'b0;
    checkOutput("clear_parity", 32'(parity_err_count), 32'd0);
    checkOutput("clear_frame", 32'(frame_err_count), 32'd0);
    checkOutput("clear_overflow2", 32'(overflow), 32'd0);

    status_clear = 1'b1; rx_frame_error = 1'b1;
    applyStimulus(1);
    status_clear = 1'b0; rx_frame_error = 1'b0;
    checkOutput("clear_with_edge_frame", 32'(frame_err_count), 32'd1);
    checkOutput("clear_with_edge_parity", 32'(parity_err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
